// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO plus load sequencer sitting directly in front of a UART
// transmitter. The CPU side pushes bytes with single-cycle writes. The
// sequencer hands them one at a time to the UART through a req/ack handshake.
// A byte is only offered while the UART reports its holding register free
// (tx_empty), so the UART never sees an overrun.
//
// Parameters
//   DEPTH_LOG2  log2 of FIFO depth (depth = 2**DEPTH_LOG2 bytes)
//
// Ports
//   clk       in   system clock, shared with the UART tx_clk
//   reset     in   asynchronous, active-high reset
//   wr        in   push wr_data this cycle
//   wr_data   in   byte to enqueue
//   full      out  FIFO holds 2**DEPTH_LOG2 bytes
//   empty     out  FIFO holds no bytes (byte already in tx_data excluded)
//   count     out  number of bytes in the FIFO
//   ovf       out  sticky flag: a push was dropped because the FIFO was full
//   ovf_clr   in   clears ovf (a same-cycle drop wins)
//   busy      out  sequencer not idle, or FIFO not empty
//   tx_req    out  load request to the UART
//   tx_ack    in   UART load acknowledge
//   tx_data   out  byte presented to the UART, held through the handshake
//   tx_empty  in   UART holding register is free
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic                  busy,
  output logic                  tx_req,
  input  logic                  tx_ack,
  output logic [7:0]            tx_data,
  input  logic                  tx_empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   tx_req_q, tx_req_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic [7:0]             mem_q [DEPTH];

  logic                   full_s;
  logic                   empty_s;
  logic                   push_s;
  logic                   drop_s;
  logic                   pop_s;

  // Occupancy flags decoded from the registered count. full is taken before
  // any same-cycle pop, so a push while full is always dropped.
  assign full_s  = (count_q == FULL_COUNT);
  assign empty_s = (count_q == '0);
  assign push_s  = wr && !full_s;
  assign drop_s  = wr && full_s;

  // Sequencer next state, pop decision and handshake output next values.
  always_comb begin
    state_d   = state_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s && tx_empty) begin
          pop_s   = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (tx_ack) begin
          state_d = ST_REL;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REL: begin
        if (!tx_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // tx_req is registered from the next state so it is high exactly in REQ.
    tx_req_d = (state_d == ST_REQ);
    if (pop_s) begin
      tx_data_d = mem_q[rd_ptr_q];
    end else begin
      tx_data_d = tx_data_q;
    end
  end

  // Pointer, count and sticky overflow next values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A dropped push sets ovf even when ovf_clr is asserted in the same cycle.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers; reset discards all queued bytes and drops tx_req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_req_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Byte storage; contents are only meaningful between the pointers, so the
  // array needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full    = full_s;
  assign empty   = empty_s;
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign busy    = (state_q != ST_IDLE) || !empty_s;
  assign tx_req  = tx_req_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       ovf_clr;
  logic       busy;
  logic       tx_req;
  logic       tx_ack;
  logic [7:0] tx_data;
  logic       tx_empty;

  int checks;
  int errors;

  // UART model state
  logic       uart_en;
  logic       hold_low;
  logic       prev_req;
  int         busy_cnt;
  int         req_rises;
  logic [7:0] rx_q [$];

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .busy     (busy),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack),
    .tx_data  (tx_data),
    .tx_empty (tx_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART: holding register busy for 10 cycles after each load.
  assign tx_empty = (busy_cnt == 0) && !hold_low;

  // UART model: acks half a cycle after req, releases ack after req drops,
  // records the byte at load time and counts request rises.
  always @(negedge clk) begin
    if (tx_req && !prev_req) req_rises = req_rises + 1;
    prev_req = tx_req;
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (uart_en) begin
      if (tx_req && !tx_ack) begin
        tx_ack = 1'b1;
        rx_q.push_back(tx_data);
        busy_cnt = 10;
      end else if (!tx_req && tx_ack) begin
        tx_ack = 1'b0;
      end
    end else begin
      tx_ack = 1'b0;
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL %s: received %0d bytes, required %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while ((busy || tx_ack || busy_cnt != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    checks++;
    if (busy || tx_ack || busy_cnt != 0) begin
      errors++;
      $display("FAIL %s: still busy=%0b after %0d cycles, required idle", name, busy, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL rst_tx_req: got %0b want 0", tx_req); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags: empty=%0b full=%0b want 1/0", empty, full); end
    checks++; if (ovf !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ovf_busy: ovf=%0b busy=%0b want 0/0", ovf, busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_byte();
    rx_q.delete();
    @(negedge clk);
    wr = 1'b1;
    wr_data = 8'h41;
    @(posedge clk); #1;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", count); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %0b want 0", tx_req); end
    @(negedge clk);
    wr = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL single_req_rise: got %0b want 1", tx_req); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data_req: got %h want 41", tx_data); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", count); end
    @(posedge clk); #1;
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL single_req_fall: got %0b want 0", tx_req); end
    checks++; if (tx_ack !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL single_data_ack: ack=%0b data=%h want 1/41", tx_ack, tx_data); end
    wait_idle(100, "single_idle");
    checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h41) begin errors++; $display("FAIL single_rx: size=%0d want 1 byte 41", rx_q.size()); end
  endtask

  task automatic test_fill_overflow();
    rx_q.delete();
    hold_low = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wr = 1'b1;
      wr_data = (i == 16) ? 8'hFF : 8'(i);
      if (i == 16) begin
        checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL fill_full: full=%0b count=%0d want 1/16", full, count); end
      end
    end
    @(negedge clk);
    wr = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %0b want 1", ovf); end
    checks++; if (count !== 5'd16 || empty !== 1'b0) begin errors++; $display("FAIL fill_count: count=%0d empty=%0b want 16/0", count, empty); end
    hold_low = 1'b0;
    wait_rx(16, 600, "fill_rx");
    wait_idle(100, "fill_idle");
    for (int i = 0; i < 16; i++) begin
      checks++; if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL fill_order[%0d]: got %h want %h", i, rx_q[i], 8'(i)); end
    end
    checks++; if (rx_q.size() !== 16) begin errors++; $display("FAIL fill_no_ff: size=%0d want 16", rx_q.size()); end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf_clr: got %0b want 0", ovf); end
  endtask

  task automatic test_gated_by_tx_empty();
    int r0;
    rx_q.delete();
    r0 = req_rises;
    hold_low = 1'b1;
    push(8'h51); push(8'h52); push(8'h53);
    repeat (50) @(posedge clk);
    #1;
    checks++; if (req_rises !== r0 || tx_req !== 1'b0) begin errors++; $display("FAIL gate_no_req: rises=%0d want %0d", req_rises - r0, 0); end
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL gate_count: got %0d want 3", count); end
    hold_low = 1'b0;
    wait_rx(3, 300, "gate_rx");
    wait_idle(100, "gate_idle");
    repeat (30) @(posedge clk);
    #1;
    checks++; if (req_rises - r0 !== 3) begin errors++; $display("FAIL gate_rises: got %0d want 3", req_rises - r0); end
    checks++; if (rx_q[0] !== 8'h51 || rx_q[1] !== 8'h52 || rx_q[2] !== 8'h53) begin errors++; $display("FAIL gate_data: got %h %h %h want 51 52 53", rx_q[0], rx_q[1], rx_q[2]); end
  endtask

  task automatic test_pop_while_full();
    rx_q.delete();
    hold_low = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr = 1'b1;
      wr_data = 8'h80 + 8'(i);
    end
    @(negedge clk);
    wr = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL pf_full: got %0b want 1", full); end
    @(negedge clk);
    hold_low = 1'b0;
    wr = 1'b1;
    wr_data = 8'hEE;
    @(posedge clk); #1;
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL pf_count: got %0d want 15", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pf_ovf: got %0b want 1", ovf); end
    checks++; if (tx_req !== 1'b1 || tx_data !== 8'h80) begin errors++; $display("FAIL pf_pop: req=%0b data=%h want 1/80", tx_req, tx_data); end
    @(negedge clk);
    wr = 1'b0;
    hold_low = 1'b1;
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL pf_ovf_clr: got %0b want 0", ovf); end
    push(8'hA0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL pf_refill: got %0d want 16", count); end
    @(negedge clk); wr = 1'b1; wr_data = 8'hBB; ovf_clr = 1'b1;
    @(negedge clk); wr = 1'b0; ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL pf_set_wins: ovf=%0b count=%0d want 1/16", ovf, count); end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    hold_low = 1'b0;
    wait_rx(17, 800, "pf_rx");
    wait_idle(100, "pf_idle");
    checks++; if (rx_q[1] !== 8'h81 || rx_q[15] !== 8'h8F || rx_q[16] !== 8'hA0 || rx_q.size() !== 17) begin errors++; $display("FAIL pf_order: got %h %h %h size %0d want 81 8f a0 17", rx_q[1], rx_q[15], rx_q[16], rx_q.size()); end
  endtask

  task automatic test_reset_mid_req();
    int r0;
    uart_en = 1'b0;
    hold_low = 1'b1;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    @(negedge clk);
    hold_low = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx_req !== 1'b1 || count !== 5'd5) begin errors++; $display("FAIL mid_setup: req=%0b count=%0d want 1/5", tx_req, count); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %0b want 0", tx_req); end
    checks++; if (count !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_flush: count=%0d empty=%0b busy=%0b want 0/1/0", count, empty, busy); end
    @(negedge clk);
    reset = 1'b0;
    uart_en = 1'b1;
    r0 = req_rises;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (req_rises !== r0 || tx_req !== 1'b0) begin errors++; $display("FAIL mid_no_req: rises=%0d want 0", req_rises - r0); end
    rx_q.delete();
    push(8'h5A);
    wait_rx(1, 50, "mid_new_rx");
    checks++; if (rx_q[0] !== 8'h5A) begin errors++; $display("FAIL mid_new_data: got %h want 5a", rx_q[0]); end
    wait_idle(100, "mid_idle");
  endtask

  task automatic test_stream_wrap();
    logic [7:0] exp_q [$];
    logic [7:0] b;
    rx_q.delete();
    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 37 + 5);
      exp_q.push_back(b);
      push(b);
      repeat ($urandom_range(4, 16)) @(negedge clk);
    end
    wait_rx(40, 1500, "stream_rx");
    wait_idle(200, "stream_idle");
    for (int i = 0; i < 40; i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (ovf !== 1'b0 || count !== 5'd0 || rx_q.size() !== 40) begin errors++; $display("FAIL stream_end: ovf=%0b count=%0d size=%0d want 0/0/40", ovf, count, rx_q.size()); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    wr = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    tx_ack = 1'b0;
    uart_en = 1'b1;
    hold_low = 1'b0;
    prev_req = 1'b0;
    busy_cnt = 0;
    req_rises = 0;
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_gated_by_tx_empty();
    test_pop_while_full();
    test_reset_mid_req();
    test_stream_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
